ibex_fetch_fifo: RTL and testbench

IBEX_FETCH_FIFO -- requirements
Module: ibex_fetch_fifo

---
 rtl/ibex_fetch_fifo_if.sv | 28 ++
 rtl/ibex_fetch_fifo.sv | 131 +++++++++++++
 tb/tb_ibex_fetch_fifo.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_fifo_if.sv
// Handshake bundle between the instruction bus, the prefetch FIFO and the IF stage.
// The FIFO sits on the slave side; the fetch controller / IF stage drive the master side.
interface ibex_fetch_fifo_if #(
  parameter int unsigned NUM_REQS = 2
);
  logic                clear_i;
  logic [NUM_REQS-1:0] busy_o;
  logic                in_valid_i;
  logic [31:0]         in_addr_i;
  logic [31:0]         in_rdata_i;
  logic                in_err_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_addr_o;
  logic [31:0]         out_rdata_o;
  logic                out_err_o;
  logic                out_err_plus2_o;

  modport master (
    output clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    input  busy_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o
  );

  modport slave (
    input  clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    output busy_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o
  );
endinterface

// File: rtl/ibex_fetch_fifo.sv
// Prefetch FIFO: buffers returned bus words and presents aligned, unaligned and
// compressed instructions to the IF stage, with a zero-latency bypass when empty.
module ibex_fetch_fifo #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_fetch_fifo_if.slave     bus
);
  localparam int unsigned DEPTH = NUM_REQS + 1;

  logic [31:0]      rdata_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] valid_q;
  logic [31:1]      addr_q;

  logic [31:0] word0_rdata;
  logic        word0_valid, err0;
  logic [15:0] word1_lo;
  logic        word1_valid, err1;
  logic        aligned, comp_aligned, comp_unaligned, is_compressed;
  logic        valid_raw, handshake, pop;
  logic        unused_addr_bit;

  logic [31:0]      comb_rdata [DEPTH+1];
  logic [DEPTH:0]   comb_valid, comb_err, occ_below;
  logic [31:0]      rdata_d [DEPTH];
  logic [DEPTH-1:0] valid_d, err_d;

  assign unused_addr_bit = bus.in_addr_i[0];

  // Incoming word stands in for an empty head slot, or for entry 1 when only the head is filled.
  always_comb begin
    word0_valid = valid_q[0] | bus.in_valid_i;
    word0_rdata = '0;
    err0        = 1'b0;
    if (valid_q[0]) begin
      word0_rdata = rdata_q[0];
      err0        = err_q[0];
    end else if (bus.in_valid_i) begin
      word0_rdata = bus.in_rdata_i;
      err0        = bus.in_err_i;
    end
    word1_valid = 1'b0;
    word1_lo    = '0;
    err1        = 1'b0;
    if (valid_q[1]) begin
      word1_valid = 1'b1;
      word1_lo    = rdata_q[1][15:0];
      err1        = err_q[1];
    end else if (valid_q[0] && bus.in_valid_i) begin
      word1_valid = 1'b1;
      word1_lo    = bus.in_rdata_i[15:0];
      err1        = bus.in_err_i;
    end
  end

  assign aligned        = ~addr_q[1];
  assign comp_aligned   = word0_rdata[1:0] != 2'b11;
  assign comp_unaligned = word0_rdata[17:16] != 2'b11;
  assign is_compressed  = aligned ? comp_aligned : comp_unaligned;

  always_comb begin
    valid_raw           = word0_valid;
    bus.out_rdata_o     = {word1_lo, word0_rdata[31:16]};
    bus.out_err_o       = err0;
    bus.out_err_plus2_o = 1'b0;
    if (aligned) begin
      bus.out_rdata_o = word0_rdata;
    end else if (!comp_unaligned) begin
      // An error on the first half is reportable without waiting for the second word.
      valid_raw           = word0_valid & (word1_valid | err0);
      bus.out_err_o       = err0 | err1;
      bus.out_err_plus2_o = err1 & ~err0;
    end
  end

  assign bus.out_valid_o = valid_raw & ~bus.clear_i;
  assign bus.out_addr_o  = {addr_q, 1'b0};
  assign bus.busy_o      = valid_q[DEPTH-1:1];
  assign handshake       = bus.out_valid_o & bus.out_ready_i;
  assign pop             = handshake & ~(aligned & comp_aligned);

  // Append the incoming word behind the stored ones, then shift out the head on a pop.
  assign occ_below = {valid_q, 1'b1};
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      comb_valid[i] = valid_q[i] | (bus.in_valid_i & ~valid_q[i] & occ_below[i]);
      comb_rdata[i] = valid_q[i] ? rdata_q[i] : bus.in_rdata_i;
      comb_err[i]   = valid_q[i] ? err_q[i]   : bus.in_err_i;
    end
    comb_valid[DEPTH] = bus.in_valid_i & valid_q[DEPTH-1];
    comb_rdata[DEPTH] = bus.in_rdata_i;
    comb_err[DEPTH]   = bus.in_err_i;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = pop ? comb_valid[i+1] : comb_valid[i];
      rdata_d[i] = pop ? comb_rdata[i+1] : comb_rdata[i];
      err_d[i]   = pop ? comb_err[i+1]   : comb_err[i];
    end
  end

  // Storage update; a flush drops every entry including any word arriving this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= '0;
    end else if (bus.clear_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  // Fetch PC advances by one halfword for compressed instructions, two otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (bus.clear_i) begin
      addr_q <= bus.in_addr_i[31:1];
    end else if (handshake) begin
      addr_q <= addr_q + (is_compressed ? 31'd1 : 31'd2);
    end
  end

  push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.in_valid_i && (&valid_q) && !pop && !bus.clear_i));

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Self-checking bench for ibex_fetch_fifo: directed scenarios plus a randomized run
// compared against a queue-based model of the instruction stream.
module tb_ibex_fetch_fifo;
  localparam int unsigned NUM_REQS = 2;
  localparam int unsigned DEPTH    = NUM_REQS + 1;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  ibex_fetch_fifo_if #(.NUM_REQS(NUM_REQS)) bus ();
  ibex_fetch_fifo #(.NUM_REQS(NUM_REQS)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Reference model: pending words in fetch order plus the current PC.
  logic [31:0] mq_data [$];
  bit          mq_err  [$];
  logic [31:0] av_data [$];
  bit          av_err  [$];
  logic [31:0] m_addr;
  bit          exp_valid, exp_err, exp_plus2, exp_comp, exp_hs, exp_pop;
  logic [31:0] exp_rdata, exp_mask, exp_step;

  task automatic drive(input bit clr, input logic [31:0] a, input bit v,
                       input logic [31:0] d, input bit e, input bit rdy);
    bus.clear_i     = clr;
    bus.in_addr_i   = a;
    bus.in_valid_i  = v;
    bus.in_rdata_i  = d;
    bus.in_err_i    = e;
    bus.out_ready_i = rdy;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_eval(input bit v, input logic [31:0] d, input bit e, input bit rdy, input bit clr);
    logic [31:0] w0, w1;
    bit e0, e1;
    av_data = mq_data;
    av_err  = mq_err;
    if (v) begin
      av_data.push_back(d);
      av_err.push_back(e);
    end
    exp_valid = 0; exp_rdata = '0; exp_mask = 32'hFFFF_FFFF;
    exp_err = 0; exp_plus2 = 0; exp_comp = 0;
    if (av_data.size() >= 1) begin
      w0 = av_data[0];
      e0 = av_err[0];
      if (m_addr[1] == 1'b0) begin
        exp_comp = (w0[1:0] != 2'b11);
        exp_valid = 1; exp_rdata = w0; exp_err = e0;
      end else begin
        exp_comp  = (w0[17:16] != 2'b11);
        exp_mask  = 32'h0000_FFFF;
        exp_rdata = {16'h0000, w0[31:16]};
        if (exp_comp) begin
          exp_valid = 1; exp_err = e0;
        end else if (av_data.size() >= 2) begin
          w1 = av_data[1];
          e1 = av_err[1];
          exp_valid = 1; exp_mask = 32'hFFFF_FFFF;
          exp_rdata = {w1[15:0], w0[31:16]};
          exp_err = e0 | e1; exp_plus2 = e1 & ~e0;
        end else if (e0) begin
          exp_valid = 1; exp_err = 1;
        end
      end
    end
    if (clr) exp_valid = 0;
    exp_hs   = exp_valid && rdy;
    exp_pop  = exp_hs && !(m_addr[1] == 1'b0 && exp_comp);
    exp_step = exp_comp ? 32'd2 : 32'd4;
  endtask

  task automatic model_commit(input bit clr, input logic [31:0] a);
    if (clr) begin
      mq_data.delete();
      mq_err.delete();
      m_addr = {a[31:1], 1'b0};
    end else begin
      if (exp_hs) m_addr = m_addr + exp_step;
      mq_data = av_data;
      mq_err  = av_err;
      if (exp_pop) begin
        void'(mq_data.pop_front());
        void'(mq_err.pop_front());
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(0, 32'h0, 0, 32'hDEAD_BEEF, 1, 1);
    #3;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid_o); end
    checks++; if (bus.out_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.out_addr_o); end
    checks++; if (bus.busy_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 00", bus.busy_o); end
    checks++; if (bus.out_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.out_err_o); end
    checks++; if (bus.out_err_plus2_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_plus2: got %b expected 0", bus.out_err_plus2_o); end
    checks++; if (bus.out_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.out_rdata_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    advance();
  endtask

  task automatic test_aligned();
    drive(1, 32'h100, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h00A0_0093, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", bus.out_valid_o); end
    checks++; if (bus.out_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL bypass_addr: got %h expected 100", bus.out_addr_o); end
    checks++; if (bus.out_rdata_o !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL bypass_rdata: got %h expected 00a00093", bus.out_rdata_o); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.out_addr_o !== 32'h104) begin errors++; $display("[TB] FAIL bypass_next_addr: got %h expected 104", bus.out_addr_o); end
    checks++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 2'b00) begin errors++; $display("[TB] FAIL bypass_empty: got valid=%b busy=%b expected 0/00", bus.out_valid_o, bus.busy_o); end
    advance();
  endtask

  task automatic test_compressed();
    drive(1, 32'h200, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h4501_4501, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h200 || bus.out_rdata_o[15:0] !== 16'h4501) begin errors++; $display("[TB] FAIL comp_first: got v=%b a=%h d=%h expected 1/200/4501", bus.out_valid_o, bus.out_addr_o, bus.out_rdata_o[15:0]); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h202 || bus.out_rdata_o[15:0] !== 16'h4501) begin errors++; $display("[TB] FAIL comp_second: got v=%b a=%h d=%h expected 1/202/4501", bus.out_valid_o, bus.out_addr_o, bus.out_rdata_o[15:0]); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.out_valid_o !== 1'b0 || bus.out_addr_o !== 32'h204) begin errors++; $display("[TB] FAIL comp_drained: got v=%b a=%h expected 0/204", bus.out_valid_o, bus.out_addr_o); end
    advance();
  endtask

  task automatic test_unaligned();
    drive(1, 32'h302, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0093_AAAA, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL unal_wait: got %b expected 0", bus.out_valid_o); end
    advance();
    drive(0, 32'h0, 1, 32'hBBBB_00A0, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h302 || bus.out_rdata_o !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL unal_join: got v=%b a=%h d=%h expected 1/302/00a00093", bus.out_valid_o, bus.out_addr_o, bus.out_rdata_o); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.out_addr_o !== 32'h306 || bus.out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL unal_next: got a=%h v=%b expected 306/0", bus.out_addr_o, bus.out_valid_o); end
    advance();
  endtask

  task automatic test_errors();
    drive(1, 32'h402, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0093_AAAA, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h1111_00A0, 1, 0); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_err_o !== 1'b1 || bus.out_err_plus2_o !== 1'b1) begin errors++; $display("[TB] FAIL err_upper: got v=%b e=%b p2=%b expected 1/1/1", bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o); end
    advance();
    drive(1, 32'h402, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0093_AAAA, 1, 0); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_err_o !== 1'b1 || bus.out_err_plus2_o !== 1'b0) begin errors++; $display("[TB] FAIL err_lower: got v=%b e=%b p2=%b expected 1/1/0", bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o); end
    advance();
    drive(1, 32'h0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h500, 0, 0, 0, 0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 1, 32'h0000_0013, 0, 0); advance();
    end
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.busy_o !== 2'b11) begin errors++; $display("[TB] FAIL full_busy: got %b expected 11", bus.busy_o); end
    advance();
    drive(0, 32'h0, 1, 32'h0000_0013, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h500) begin errors++; $display("[TB] FAIL full_pushpop: got v=%b a=%h expected 1/500", bus.out_valid_o, bus.out_addr_o); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.busy_o !== 2'b11 || bus.out_addr_o !== 32'h504) begin errors++; $display("[TB] FAIL full_steady: got busy=%b a=%h expected 11/504", bus.busy_o, bus.out_addr_o); end
    advance();
    drive(1, 32'h700, 1, 32'h0000_0013, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_valid: got %b expected 0", bus.out_valid_o); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.busy_o !== 2'b00 || bus.out_valid_o !== 1'b0 || bus.out_addr_o !== 32'h700) begin errors++; $display("[TB] FAIL clear_empty: got busy=%b v=%b a=%h expected 00/0/700", bus.busy_o, bus.out_valid_o, bus.out_addr_o); end
    advance();
  endtask

  task automatic test_async_reset();
    drive(1, 32'h600, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0000_0013, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0000_0013, 0, 0); advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.busy_o !== 2'b01 || bus.out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got busy=%b v=%b expected 01/1", bus.busy_o, bus.out_valid_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 2'b00 || bus.out_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL async_reset: got v=%b busy=%b a=%h expected 0/00/0", bus.out_valid_o, bus.busy_o, bus.out_addr_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    advance();
  endtask

  task automatic test_wrap();
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0); advance();
    drive(0, 32'h0, 1, 32'h0000_0013, 0, 1); settle();
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pre: got v=%b a=%h expected 1/fffffffc", bus.out_valid_o, bus.out_addr_o); end
    advance();
    drive(0, 32'h0, 0, 0, 0, 0); settle();
    checks++; if (bus.out_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_post: got %h expected 0", bus.out_addr_o); end
    advance();
  endtask

  task automatic test_random();
    bit clr, v, e, rdy;
    logic [31:0] a, d;
    logic [NUM_REQS-1:0] eb;
    drive(1, 32'h1000, 0, 0, 0, 0); advance();
    mq_data.delete();
    mq_err.delete();
    m_addr = 32'h1000;
    for (int n = 0; n < 800; n++) begin
      clr = ($urandom_range(0, 29) == 0);
      a   = $urandom;
      d   = $urandom;
      if ($urandom_range(0, 2) == 0) d[1:0] = 2'b11;
      if ($urandom_range(0, 2) == 0) d[17:16] = 2'b11;
      e   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      v   = ($urandom_range(0, 1) == 1);
      if (mq_data.size() >= DEPTH && !clr) begin
        model_eval(0, d, e, rdy, clr);
        if (!exp_pop) v = 0;
      end
      model_eval(v, d, e, rdy, clr);
      for (int i = 0; i < NUM_REQS; i++) eb[i] = (mq_data.size() > i + 1);
      drive(clr, a, v, d, e, rdy);
      settle();
      checks++; if (bus.out_valid_o !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", n, bus.out_valid_o, exp_valid); end
      checks++; if (bus.out_addr_o !== m_addr) begin errors++; $display("[TB] FAIL rnd_addr[%0d]: got %h expected %h", n, bus.out_addr_o, m_addr); end
      checks++; if (bus.busy_o !== eb) begin errors++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", n, bus.busy_o, eb); end
      if (exp_valid) begin
        checks++; if ((bus.out_rdata_o & exp_mask) !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", n, bus.out_rdata_o & exp_mask, exp_rdata); end
        checks++; if (bus.out_err_o !== exp_err || bus.out_err_plus2_o !== exp_plus2) begin errors++; $display("[TB] FAIL rnd_err[%0d]: got %b/%b expected %b/%b", n, bus.out_err_o, bus.out_err_plus2_o, exp_err, exp_plus2); end
      end
      model_commit(clr, a);
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_compressed();
    test_unaligned();
    test_errors();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end
endmodule
